// File: rtl/fastica_pkg.sv
// fastica_pkg: shared state encoding, mode encoding and width helper for the FastICA sequencer
package fastica_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ORTH   = 4'd1,
        S_ORTH_W = 4'd2,
        S_NORM   = 4'd3,
        S_FAST   = 4'd4,
        S_FAST_W = 4'd5,
        S_ERR    = 4'd6,
        S_ERR_W  = 4'd7,
        S_MUL    = 4'd8,
        S_STORE  = 4'd9,
        S_NEXT   = 4'd10,
        S_DONE   = 4'd11,
        S_FAIL   = 4'd12
    } state_e;

    typedef enum logic {
        MODE_SYMM = 1'b0,
        MODE_DEFL = 1'b1
    } mode_e;

    // Bit width needed to index n items, never less than one bit
    function automatic int fa_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fastica_wait_timer.sv
// fastica_wait_timer: busy-wait tracker with first-cycle mask and watchdog, shared by all wait states
module fastica_wait_timer
    import fastica_pkg::*;
#(
    parameter int  WDOG_CYCLES = 1024,
    localparam int WW          = fa_width(WDOG_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic busy_i,
    output logic wait_done_o,
    output logic wait_tmo_o
);

    logic [WW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of wait cycles already completed, so zero marks the masked first cycle
    assign cnt_d       = active_i ? cnt_q + 1'b1 : '0;
    assign wait_done_o = active_i && (cnt_q != '0) && !busy_i;
    assign wait_tmo_o  = active_i && (cnt_q == WW'(WDOG_CYCLES - 1));

    // Count cycles in the current wait; leaving the wait clears it for the next entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fastica_seq_ctrl.sv
// fastica_seq_ctrl: top-level FastICA sequencer (orth/norm/fixed-point/error loop, then multiply/store)
module fastica_seq_ctrl
    import fastica_pkg::*;
#(
    parameter int  NUM_COMP       = 4,
    parameter int  WORDS_PER_COMP = 4,
    parameter int  MAX_ITER       = 64,
    parameter int  WDOG_CYCLES    = 1024,
    localparam int CW             = fa_width(NUM_COMP),
    localparam int IW             = fa_width(MAX_ITER),
    localparam int AW             = fa_width(NUM_COMP * WORDS_PER_COMP)
) (
    input  logic          clk_fastica,
    input  logic          go_fastica,
    input  logic          mode_defl,
    input  logic          symm_busy,
    input  logic          fast_busy,
    input  logic          error_busy,
    input  logic          converged,
    output logic          go_symm,
    output logic          go_fast,
    output logic          go_error,
    output logic          en_norm,
    output logic          en_mul1,
    output logic          en_mem1,
    output logic          rw,
    output logic [AW-1:0] mem_addr,
    output logic [CW-1:0] comp_idx,
    output logic [IW-1:0] iter_cnt,
    output logic          fastica_busy,
    output logic          fastica_done,
    output logic          fastica_fail
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [CW-1:0] comp_q, comp_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          in_wait, wait_busy, wait_done, wait_tmo;
    logic [AW-1:0] base_addr, last_addr;

    assign in_wait   = (state_q == S_ORTH_W) || (state_q == S_FAST_W) || (state_q == S_ERR_W);
    assign wait_busy = (state_q == S_ORTH_W) ? symm_busy :
                       (state_q == S_FAST_W) ? fast_busy : error_busy;
    assign base_addr = (mode_q == MODE_DEFL) ? AW'(int'(comp_q) * WORDS_PER_COMP) : '0;
    assign last_addr = (mode_q == MODE_DEFL) ? AW'(int'(comp_q) * WORDS_PER_COMP + WORDS_PER_COMP - 1)
                                             : AW'(NUM_COMP * WORDS_PER_COMP - 1);

    fastica_wait_timer #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wait (
        .clk_i      (clk_fastica),
        .rst_ni     (go_fastica),
        .active_i   (in_wait),
        .busy_i     (wait_busy),
        .wait_done_o(wait_done),
        .wait_tmo_o (wait_tmo)
    );

    // State and counter registers; go_fastica low returns everything to idle at once
    always_ff @(posedge clk_fastica or negedge go_fastica) begin
        if (!go_fastica) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_SYMM;
            comp_q  <= '0;
            iter_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            comp_q  <= comp_d;
            iter_q  <= iter_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state sequencing; counters only move on the transitions that own them
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        comp_d  = comp_q;
        iter_d  = iter_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                mode_d  = mode_e'(mode_defl);
                state_d = S_ORTH;
            end
            S_ORTH:   state_d = S_ORTH_W;
            S_ORTH_W: state_d = wait_done ? S_NORM : (wait_tmo ? S_FAIL : S_ORTH_W);
            S_NORM:   state_d = S_FAST;
            S_FAST:   state_d = S_FAST_W;
            S_FAST_W: state_d = wait_done ? S_ERR : (wait_tmo ? S_FAIL : S_FAST_W);
            S_ERR:    state_d = S_ERR_W;
            S_ERR_W: begin
                if (wait_done) begin
                    if (converged) begin
                        state_d = S_MUL;
                    end else if (iter_q == IW'(MAX_ITER - 1)) begin
                        state_d = S_FAIL;
                    end else begin
                        iter_d  = iter_q + 1'b1;
                        state_d = S_ORTH;
                    end
                end else if (wait_tmo) begin
                    state_d = S_FAIL;
                end
            end
            S_MUL: begin
                addr_d  = base_addr;
                state_d = S_STORE;
            end
            S_STORE: begin
                if (addr_q == last_addr) state_d = S_NEXT;
                else                     addr_d  = addr_q + 1'b1;
            end
            S_NEXT: begin
                if (mode_q == MODE_DEFL && comp_q != CW'(NUM_COMP - 1)) begin
                    comp_d  = comp_q + 1'b1;
                    iter_d  = '0;
                    state_d = S_ORTH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase
    end

    assign go_symm      = (state_q == S_ORTH);
    assign en_norm      = (state_q == S_NORM);
    assign go_fast      = (state_q == S_FAST);
    assign go_error     = (state_q == S_ERR);
    assign en_mul1      = (state_q == S_MUL) || (state_q == S_STORE);
    assign en_mem1      = (state_q == S_STORE);
    assign rw           = (state_q == S_STORE);
    assign mem_addr     = addr_q;
    assign comp_idx     = comp_q;
    assign iter_cnt     = iter_q;
    assign fastica_busy = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign fastica_done = (state_q == S_DONE);
    assign fastica_fail = (state_q == S_FAIL);

endmodule

// File: tb/tb_fastica_seq_ctrl.sv
// tb_fastica_seq_ctrl: directed bench for the FastICA sequencer with simple busy responders
module tb_fastica_seq_ctrl;

    logic       clk_fastica = 1'b0;
    logic       go_fastica;
    logic       mode_defl;
    logic       symm_busy, fast_busy, error_busy, converged;
    logic       go_symm, go_fast, go_error, en_norm, en_mul1, en_mem1, rw;
    logic [3:0] mem_addr;
    logic [1:0] comp_idx;
    logic [5:0] iter_cnt;
    logic       fastica_busy, fastica_done, fastica_fail;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int conv_sel = 0;
    int sb_hi = 0;
    int fb_lat = 0;
    logic sb_stuck = 1'b0;
    logic fb_stuck = 1'b0;
    logic defl_run = 1'b0;
    int sb_cnt = 0;
    int fb_rem = 0;
    int n_goerr, n_gosymm, n_norm, n_mem, t_symm, t_fast, gap_sn, gap_fe, gap_sf;
    logic fail_seen;

    fastica_seq_ctrl dut (
        .clk_fastica (clk_fastica),
        .go_fastica  (go_fastica),
        .mode_defl   (mode_defl),
        .symm_busy   (symm_busy),
        .fast_busy   (fast_busy),
        .error_busy  (error_busy),
        .converged   (converged),
        .go_symm     (go_symm),
        .go_fast     (go_fast),
        .go_error    (go_error),
        .en_norm     (en_norm),
        .en_mul1     (en_mul1),
        .en_mem1     (en_mem1),
        .rw          (rw),
        .mem_addr    (mem_addr),
        .comp_idx    (comp_idx),
        .iter_cnt    (iter_cnt),
        .fastica_busy(fastica_busy),
        .fastica_done(fastica_done),
        .fastica_fail(fastica_fail)
    );

    always #5 clk_fastica = ~clk_fastica;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Sub-block stand-ins: symm_busy rises in the 2nd wait cycle for a window, fast_busy for fb_lat cycles
    always @(posedge clk_fastica) begin
        cyc++;
        sb_cnt <= !go_fastica ? 0 : go_symm ? 1 : (sb_cnt != 0 && sb_cnt < 4000) ? sb_cnt + 1 : sb_cnt;
        fb_rem <= !go_fastica ? 0 : go_fast ? fb_lat : (fb_rem != 0) ? fb_rem - 1 : 0;
    end

    assign symm_busy  = sb_stuck || (sb_cnt >= 2 && sb_cnt <= sb_hi);
    assign fast_busy  = fb_stuck || (fb_rem != 0);
    assign error_busy = 1'b0;
    assign converged  = (conv_sel == 0) ? 1'b1 : (conv_sel == 1) ? (iter_cnt == 6'd2) : 1'b0;

    // Event monitor: counts pulses, measures wait gaps and checks every store write
    always @(negedge clk_fastica) begin
        if (!go_fastica) begin
            n_goerr = 0; n_gosymm = 0; n_norm = 0; n_mem = 0;
            t_symm = 0; t_fast = 0; gap_sn = 0; gap_fe = 0; gap_sf = 0;
            fail_seen = 1'b0;
        end else begin
            if (go_symm) begin t_symm = cyc; n_gosymm++; end
            if (en_norm) begin gap_sn = cyc - t_symm; n_norm++; end
            if (go_fast) t_fast = cyc;
            if (go_error) begin gap_fe = cyc - t_fast; n_goerr++; end
            if (fastica_fail && !fail_seen) begin fail_seen = 1'b1; gap_sf = cyc - t_symm; end
            if (en_mem1) begin
                chk("wr_addr", 32'(mem_addr), 32'(n_mem));
                chk("wr_comp", 32'(comp_idx), defl_run ? 32'(n_mem / 4) : 32'd0);
                chk("wr_rw_mul", 32'({rw, en_mul1}), 32'd3);
                n_mem++;
            end
        end
    end

    task automatic restart(input logic defl);
        @(negedge clk_fastica);
        go_fastica = 1'b0;
        mode_defl  = defl;
        defl_run   = defl;
        @(negedge clk_fastica);
        @(negedge clk_fastica);
        go_fastica = 1'b1;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int k = 0;
        while (!(fastica_done || fastica_fail) && k < budget) begin
            @(negedge clk_fastica);
            k++;
        end
        @(negedge clk_fastica);
        chk(tag, 32'(fastica_done | fastica_fail), 32'd1);
    endtask

    initial begin
        int k;
        go_fastica = 1'b0;
        mode_defl  = 1'b0;
        @(negedge clk_fastica);
        chk("rst_busy", 32'(fastica_busy), 32'd0);
        chk("rst_stat", 32'({fastica_done, fastica_fail}), 32'd0);
        chk("rst_go", 32'({go_symm, go_fast, go_error, en_norm, en_mul1, en_mem1, rw}), 32'd0);
        chk("rst_cnt", 32'({mem_addr, comp_idx, iter_cnt}), 32'd0);

        // Symmetric, converge at once, fast_busy held 3 cycles, mode pin flipped mid-run
        conv_sel = 0; fb_lat = 3; sb_hi = 0;
        restart(1'b0);
        repeat (4) @(negedge clk_fastica);
        mode_defl = 1'b1;
        wait_end("symm_end", 300);
        chk("symm_done", 32'({fastica_done, fastica_fail}), 32'd2);
        chk("symm_writes", 32'(n_mem), 32'd16);
        chk("symm_iter", 32'(iter_cnt), 32'd0);
        chk("symm_comp", 32'(comp_idx), 32'd0);
        chk("symm_goerr", 32'(n_goerr), 32'd1);
        chk("symm_gap_fe", 32'(gap_fe), 32'd5);
        chk("symm_gap_sn", 32'(gap_sn), 32'd3);
        chk("symm_busy_end", 32'(fastica_busy), 32'd0);

        // Deflation, converge on 3rd iteration per component, symm_busy rises only in 2nd wait cycle
        conv_sel = 1; fb_lat = 0; sb_hi = 5;
        restart(1'b1);
        repeat (6) @(negedge clk_fastica);
        mode_defl = 1'b0;
        wait_end("defl_end", 1000);
        chk("defl_done", 32'({fastica_done, fastica_fail}), 32'd2);
        chk("defl_writes", 32'(n_mem), 32'd16);
        chk("defl_comp", 32'(comp_idx), 32'd3);
        chk("defl_iter", 32'(iter_cnt), 32'd2);
        chk("defl_goerr", 32'(n_goerr), 32'd12);
        chk("defl_gosymm", 32'(n_gosymm), 32'd12);
        chk("defl_gap_sn", 32'(gap_sn), 32'd7);
        chk("defl_gap_fe", 32'(gap_fe), 32'd3);
        repeat (3) @(negedge clk_fastica);
        chk("defl_hold", 32'({fastica_done, comp_idx, iter_cnt}), 32'({1'b1, 2'd3, 6'd2}));

        // Never converges: iteration limit
        conv_sel = 2; sb_hi = 0;
        restart(1'b0);
        wait_end("noconv_end", 2000);
        chk("noconv_stat", 32'({fastica_done, fastica_fail}), 32'd1);
        chk("noconv_goerr", 32'(n_goerr), 32'd64);
        chk("noconv_iter", 32'(iter_cnt), 32'd63);
        chk("noconv_mem", 32'(n_mem), 32'd0);
        chk("noconv_busy", 32'(fastica_busy), 32'd0);

        // symm_busy stuck: watchdog after 1024 ORTH_W cycles
        conv_sel = 0; sb_stuck = 1'b1;
        restart(1'b0);
        wait_end("wdog_end", 1500);
        chk("wdog_stat", 32'({fastica_done, fastica_fail}), 32'd1);
        chk("wdog_gap", 32'(gap_sf), 32'd1025);
        chk("wdog_norm", 32'(n_norm), 32'd0);
        chk("wdog_iter", 32'(iter_cnt), 32'd0);
        sb_stuck = 1'b0;

        // Asynchronous reset pulse while parked in FAST_W on the third pass
        conv_sel = 2;
        restart(1'b0);
        k = 0;
        while (n_goerr < 2 && k < 200) begin @(negedge clk_fastica); k++; end
        fb_stuck = 1'b1;
        k = 0;
        while (!go_fast && k < 50) begin @(negedge clk_fastica); k++; end
        repeat (3) @(negedge clk_fastica);
        chk("mid_pre_iter", 32'(iter_cnt), 32'd2);
        chk("mid_pre_busy", 32'(fastica_busy), 32'd1);
        #2 go_fastica = 1'b0;
        #1;
        chk("mid_busy", 32'(fastica_busy), 32'd0);
        chk("mid_go", 32'({go_symm, go_fast, go_error, en_norm}), 32'd0);
        chk("mid_iter", 32'(iter_cnt), 32'd0);
        go_fastica = 1'b1;
        @(negedge clk_fastica);
        chk("mid_restart", 32'(go_symm), 32'd1);
        fb_stuck = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
